// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU MEM stage, a DMA/accelerator port and Data_Mem.
// The slave modport is the arbiter; the master modport drives the requests and memory read data.
interface dmem_arbiter_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 64
);
   logic              cpu_req_i;
   logic              cpu_we_i;
   logic [ADDR_W-1:0] cpu_addr_i;
   logic [DATA_W-1:0] cpu_wdata_i;
   logic              cpu_gnt_o;
   logic              cpu_stall_o;
   logic              cpu_rvalid_o;
   logic [DATA_W-1:0] cpu_rdata_o;

   logic              dma_req_i;
   logic              dma_we_i;
   logic              dma_last_i;
   logic [ADDR_W-1:0] dma_addr_i;
   logic [DATA_W-1:0] dma_wdata_i;
   logic              dma_gnt_o;
   logic              dma_rvalid_o;
   logic [DATA_W-1:0] dma_rdata_o;

   logic              mem_read_o;
   logic              mem_write_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [DATA_W-1:0] mem_rdata_i;

   modport slave (
      input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
      output cpu_gnt_o, cpu_stall_o, cpu_rvalid_o, cpu_rdata_o,
      input  dma_req_i, dma_we_i, dma_last_i, dma_addr_i, dma_wdata_i,
      output dma_gnt_o, dma_rvalid_o, dma_rdata_o,
      output mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o,
      input  mem_rdata_i
   );

   modport master (
      output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
      input  cpu_gnt_o, cpu_stall_o, cpu_rvalid_o, cpu_rdata_o,
      output dma_req_i, dma_we_i, dma_last_i, dma_addr_i, dma_wdata_i,
      input  dma_gnt_o, dma_rvalid_o, dma_rdata_o,
      input  mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o,
      output mem_rdata_i
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one Data_Mem port between the CPU (single access)
// and a DMA master (bursts of up to MAX_BURST beats), with 1-cycle read return.
module dmem_arbiter #(
   parameter int DATA_W    = 64,
   parameter int ADDR_W    = 64,
   parameter int MAX_BURST = 4
) (
   input logic          clk_i,
   input logic          rst_i,
   dmem_arbiter_if.slave bus
);
   localparam int CNT_W = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

   typedef enum logic [1:0] {IDLE, SERVE_CPU, SERVE_DMA} state_e;
   localparam logic LS_CPU = 1'b0;
   localparam logic LS_DMA = 1'b1;

   state_e            state_q;
   logic              last_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              cpu_rvalid_q, dma_rvalid_q;
   logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;
   logic              cpu_gnt, dma_gnt;

   // The owner comes from the registered state; the live req only confirms the
   // beat, and a beat coinciding with reset is dropped.
   assign cpu_gnt = (state_q == SERVE_CPU) & bus.cpu_req_i & ~rst_i;
   assign dma_gnt = (state_q == SERVE_DMA) & bus.dma_req_i & ~rst_i;

   assign bus.cpu_gnt_o    = cpu_gnt;
   assign bus.dma_gnt_o    = dma_gnt;
   assign bus.cpu_stall_o  = bus.cpu_req_i & ~cpu_gnt;
   assign bus.mem_read_o   = (cpu_gnt & ~bus.cpu_we_i) | (dma_gnt & ~bus.dma_we_i);
   assign bus.mem_write_o  = (cpu_gnt &  bus.cpu_we_i) | (dma_gnt &  bus.dma_we_i);
   assign bus.mem_addr_o   = dma_gnt ? bus.dma_addr_i  : bus.cpu_addr_i;
   assign bus.mem_wdata_o  = dma_gnt ? bus.dma_wdata_i : bus.cpu_wdata_i;
   assign bus.cpu_rvalid_o = cpu_rvalid_q;
   assign bus.cpu_rdata_o  = cpu_rdata_q;
   assign bus.dma_rvalid_o = dma_rvalid_q;
   assign bus.dma_rdata_o  = dma_rdata_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         last_q       <= LS_DMA;
         cnt_q        <= '0;
         cpu_rvalid_q <= 1'b0;
         dma_rvalid_q <= 1'b0;
         cpu_rdata_q  <= '0;
         dma_rdata_q  <= '0;
      end else begin
         cpu_rvalid_q <= cpu_gnt & ~bus.cpu_we_i;
         dma_rvalid_q <= dma_gnt & ~bus.dma_we_i;
         if (cpu_gnt & ~bus.cpu_we_i) cpu_rdata_q <= bus.mem_rdata_i;
         if (dma_gnt & ~bus.dma_we_i) dma_rdata_q <= bus.mem_rdata_i;

         case (state_q)
            IDLE: begin
               // On a tie the requester not served last wins.
               if (bus.cpu_req_i && (!bus.dma_req_i || last_q == LS_DMA))
                  state_q <= SERVE_CPU;
               else if (bus.dma_req_i)
                  state_q <= SERVE_DMA;
            end
            SERVE_CPU: begin
               state_q <= IDLE;
               last_q  <= LS_CPU;
            end
            SERVE_DMA: begin
               if (bus.dma_req_i && !bus.dma_last_i && cnt_q < LAST_BEAT) begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end else begin
                  state_q <= IDLE;
                  last_q  <= LS_DMA;
                  cnt_q   <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
